mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//   Memory-access stage directly downstream of execute. Consumes the ALU result
//   (address or value) and the store data (rt), and performs word loads/stores
//   to a local data memory with configurable wait states.
//   Drives stall_flag back to the upstream stages while an access is in flight.
//   Presents a registered writeback bundle to the register file.
// PARAMETERS
//   DEPTH_WORDS  256  data memory depth in 32-bit words (power of 2)
//   MEM_LAT      2    wait cycles per load/store, 0..7
// PORTS
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-low reset
//   in_valid      in   1   execute output valid this cycle
//   mem_read      in   1   op is a load (lw)
//   mem_write     in   1   op is a store (sw)
//   reg_write     in   1   op writes the register file
//   alu_result    in   32  byte address for lw/sw, otherwise the result value
//   store_data    in   32  rt value written by sw
//   dest_reg      in   5   destination register number
//   stall_flag    out  1   upstream holds all inputs stable while high
//   wb_valid      out  1   one-cycle pulse: writeback bundle valid
//   wb_reg_write  out  1   register file write enable for this bundle
//   wb_dest       out  5   destination register
//   wb_data       out  32  load data or passed-through alu_result
//   misalign      out  1   misaligned-access flag (0 unless MEM_MISALIGN_TRAP_EN)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, counter=0; stall_flag, wb_valid,
//     wb_reg_write, misalign=0; wb_dest=0; wb_data=0. Memory contents are NOT cleared.
//   - FSM IDLE -> WAIT -> IDLE. New ops are accepted only in IDLE.
//   - Non-memory op (in_valid & !mem_read & !mem_write): accepted in IDLE.
//     Next edge: wb_valid=1, wb_data=alu_result, wb_dest=dest_reg,
//     wb_reg_write=reg_write. Latency is 1 cycle and no stall.
//   - Memory op accepted with MEM_LAT>0: go to WAIT and latch addr, data, dest, and type.
//     Counter loads MEM_LAT-1 and decrements each cycle in WAIT.
//     At counter==0 the access completes and the FSM returns to IDLE.
//     wb_valid pulses on the edge that leaves WAIT.
//     Accept-to-wb_valid latency is MEM_LAT+1 cycles.
//   - stall_flag is combinational: (state==WAIT) |
//     (state==IDLE & in_valid & (mem_read|mem_write) & MEM_LAT!=0).
//     It deasserts in the completion cycle, so the next op can be accepted on that edge.
//   - MEM_LAT==0: the access completes on the accept edge, like a non-memory op.
//     stall_flag never asserts.
//   - Load: wb_data=mem[word_idx], wb_reg_write=reg_write.
//   - Store: mem[word_idx]<=store_data on the completion edge. wb_valid pulses
//     with wb_reg_write=0.
//   - word_idx=alu_result[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so
//     out-of-range addresses wrap modulo DEPTH_WORDS.
//   - mem_read & mem_write both high: treated as a store; the read is ignored.
//   - in_valid low in IDLE: wb_valid=0 on the next edge; other wb_* outputs hold.
//   - Reset mid-WAIT: the pending op is dropped, no memory write occurs, and no wb_valid is produced.
// CONFIGURATION
//   MEM_MISALIGN_TRAP_EN defined:
//     - lw/sw with alu_result[1:0]!=0 asserts misalign for 1 cycle, in place of wb_valid.
//     - Memory is not written, the register file is not written, and no wait states are used.
//   MEM_MISALIGN_TRAP_EN undefined:
//     - alu_result[1:0] is ignored (access is word-aligned down).
//     - misalign is tied to 0.
// STRUCTURE
//   - Package mem_pkg: state enum {IDLE, WAIT}, DATA_W=32, REG_W=5,
//     MEM_LAT_MAX=7, and the clog2-based ADDR_W helper.
//   - Sub-module data_mem: DEPTH_WORDS x 32, synchronous write, asynchronous read,
//     single port, no reset.
//   - mem_stage holds the FSM, the wait counter, the latch registers and the writeback registers.
// TESTING
//   1. Non-memory op, alu_result=0x0000_002A, dest=5, reg_write=1 -> next cycle
//      wb_valid=1, wb_data=0x2A, wb_dest=5; stall_flag stays 0.
//   2. MEM_LAT=2: sw addr 0x10, data 0xDEADBEEF, then lw addr 0x10, dest=9 ->
//      stall_flag high 2 cycles per op; load wb_data=0xDEADBEEF 3 cycles after accept.
//   3. DEPTH_WORDS=256: sw addr 0x400 data 0x1234, then lw addr 0x000 ->
//      wb_data=0x1234 (wrap).
//   4. Reset pulse during WAIT of sw addr 0x20 data 0x5555 -> no wb_valid;
//      a later lw 0x20 returns the prior contents.
//   5. MEM_LAT=0: back-to-back lw/sw/add every cycle -> stall_flag never 1;
//      one wb_valid per cycle.
//   6. With MEM_MISALIGN_TRAP_EN: lw addr 0x13 -> misalign=1 for one cycle, wb_valid=0.
//      Without the macro: the same op reads word 0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and address helper for the memory stage
package mem_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - execute-to-memory request and writeback bundle
interface mem_stage_if;
  import mem_pkg::*;

  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              stall_flag;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              misalign;

  modport master (
    output in_valid, mem_read, mem_write, reg_write, alu_result, store_data, dest_reg,
    input  stall_flag, wb_valid, wb_reg_write, wb_dest, wb_data, misalign
  );

  modport slave (
    input  in_valid, mem_read, mem_write, reg_write, alu_result, store_data, dest_reg,
    output stall_flag, wb_valid, wb_reg_write, wb_dest, wb_data, misalign
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - single-port word memory, sync write, async read, no reset
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage with wait-state FSM and registered writeback
// Optional MEM_MISALIGN_TRAP_EN: misaligned lw/sw raise misalign instead of accessing memory.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LAT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  localparam int               AW       = addr_w(DEPTH_WORDS);
  localparam bit               HAS_WAIT = (MEM_LAT != 0);
  localparam logic [CNT_W-1:0] LAT_M1   = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [AW-1:0]     lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic [REG_W-1:0]  lat_dest;
  logic              lat_store;
  logic              lat_rw;

  logic              wb_valid_q, wb_rw_q, mis_q;
  logic [REG_W-1:0]  wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              in_mem, in_store, in_mis;
  logic [AW-1:0]     in_idx, mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;
  logic              stall, accept_lat, done_idle, done_wait, trap;
  logic              unused_addr_bits;

  assign in_mem   = bus.mem_read | bus.mem_write;
  assign in_store = bus.mem_write;
  assign in_idx   = bus.alu_result[AW+1:2];
  assign unused_addr_bits = ^{bus.alu_result[DATA_W-1:AW+2], bus.alu_result[1:0]};

`ifdef MEM_MISALIGN_TRAP_EN
  assign in_mis = in_mem & (bus.alu_result[1:0] != 2'b00);
`else
  assign in_mis = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall      = 1'b0;
    accept_lat = 1'b0;
    done_idle  = 1'b0;
    done_wait  = 1'b0;
    trap       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (in_mis) begin
            trap = 1'b1;
          end else if (in_mem && HAS_WAIT) begin
            accept_lat = 1'b1;
            stall      = 1'b1;
            state_nxt  = WAIT;
            cnt_nxt    = LAT_M1;
          end else begin
            done_idle = 1'b1;
          end
        end
      end
      WAIT: begin
        // Stall drops in the completion cycle so upstream advances on the leaving edge.
        if (cnt == '0) begin
          done_wait = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          stall   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = (state == WAIT) ? lat_idx  : in_idx;
  assign mem_wdata = (state == WAIT) ? lat_data : bus.store_data;
  assign mem_we    = reset & ((done_idle & in_store) | (done_wait & lat_store));

  data_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_idx    <= '0;
      lat_data   <= '0;
      lat_dest   <= '0;
      lat_store  <= 1'b0;
      lat_rw     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wb_valid_q <= 1'b0;
      mis_q      <= trap;
      if (accept_lat) begin
        lat_idx   <= in_idx;
        lat_data  <= bus.store_data;
        lat_dest  <= bus.dest_reg;
        lat_store <= in_store;
        lat_rw    <= bus.reg_write;
      end
      if (done_idle) begin
        wb_valid_q <= 1'b1;
        wb_dest_q  <= bus.dest_reg;
        if (in_store) begin
          wb_rw_q <= 1'b0;
        end else begin
          wb_rw_q   <= bus.reg_write;
          wb_data_q <= bus.mem_read ? mem_rdata : bus.alu_result;
        end
      end
      if (done_wait) begin
        wb_valid_q <= 1'b1;
        wb_dest_q  <= lat_dest;
        if (lat_store) begin
          wb_rw_q <= 1'b0;
        end else begin
          wb_rw_q   <= lat_rw;
          wb_data_q <= mem_rdata;
        end
      end
    end
  end

  assign bus.stall_flag   = stall;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_rw_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign     = mis_q;

endmodule
